// File: rtl/subset_sum_enum_pkg.sv
// Shared constants, state encoding and width helpers for the subset-sum enumerator.
// Optional sol_count output is enabled with SUBSET_ENUM_COUNT_EN.
package subset_sum_pkg;
  localparam int DEF_N     = 4;
  localparam int DEF_IDX_W = 5;
  localparam int DEF_SUM_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD,
    DONE
  } state_e;

  function automatic int sum_w(input int idx_w);
    return idx_w + 2;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n * n * n + 1);
  endfunction
endpackage

// File: rtl/subset_sum_enum_if.sv
// Host-side control and solution stream of the subset-sum enumerator.
// sol_count exists only when SUBSET_ENUM_COUNT_EN is defined.
interface subset_sum_enum_if
  import subset_sum_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = DEF_IDX_W,
  parameter int SUM_W = DEF_SUM_W
);
  logic             start;
  logic [SUM_W-1:0] psum;
  logic             busy;
  logic             sol_valid;
  logic             sol_ready;
  logic [IDX_W-1:0] sol_a;
  logic [IDX_W-1:0] sol_b;
  logic [IDX_W-1:0] sol_c;
  logic             done;
`ifdef SUBSET_ENUM_COUNT_EN
  logic [cnt_w(N)-1:0] sol_count;
`endif

  modport master (
    output start, psum, sol_ready,
`ifdef SUBSET_ENUM_COUNT_EN
    input  sol_count,
`endif
    input  busy, sol_valid, sol_a, sol_b, sol_c, done
  );

  modport slave (
    input  start, psum, sol_ready,
`ifdef SUBSET_ENUM_COUNT_EN
    output sol_count,
`endif
    output busy, sol_valid, sol_a, sol_b, sol_c, done
  );
endinterface

// File: rtl/subset_sum_enum_triple_check.sv
// Combinational acceptance rule for one (a, b, c) candidate against psum.
// Shared with the partial-sum checker so both sides agree on acceptance.
module triple_check
  import subset_sum_pkg::*;
#(
  parameter int IDX_W = DEF_IDX_W,
  parameter int SUM_W = DEF_SUM_W
) (
  input  logic [IDX_W-1:0] a,
  input  logic [IDX_W-1:0] b,
  input  logic [IDX_W-1:0] c,
  input  logic [SUM_W-1:0] psum,
  output logic             accept
);
  localparam int SW = sum_w(IDX_W);
  localparam int CW = (SW > SUM_W) ? SW : SUM_W;

  logic [SW-1:0] sum;
  logic [CW-1:0] sum_x;
  logic [CW-1:0] psum_x;
  logic          nz_ok;

  assign sum    = SW'(a) + SW'(b) + SW'(c);
  assign sum_x  = CW'(sum);
  assign psum_x = CW'(psum);
  // a == 0 only passes with two distinct nonzero tail indices
  assign nz_ok  = (a != '0) || ((b != '0) && (c != '0) && (b != c));
  assign accept = (sum_x == psum_x) && nz_ok;
endmodule

// File: rtl/subset_sum_enum.sv
// Lexicographic (a,b,c) scanner streaming accepted triples over valid/ready.
// Define SUBSET_ENUM_COUNT_EN to add the sol_count handshake counter.
module subset_sum_enum
  import subset_sum_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = DEF_IDX_W,
  parameter int SUM_W = DEF_SUM_W
) (
  input logic              clk,
  input logic              rst_n,
  subset_sum_enum_if.slave bus
);
  localparam logic [IDX_W-1:0] MAXI = IDX_W'(N - 1);

  state_e           state_q;
  logic [IDX_W-1:0] a_q, b_q, c_q;
  logic [IDX_W-1:0] a_d, b_d, c_d;
  logic [IDX_W-1:0] sa_q, sb_q, sc_q;
  logic [SUM_W-1:0] psum_q;
  logic             busy_q, valid_q, done_q;
  logic             hold_last_q;
  logic             accept, last;
`ifdef SUBSET_ENUM_COUNT_EN
  logic [cnt_w(N)-1:0] cnt_q;
`endif

  triple_check #(.IDX_W(IDX_W), .SUM_W(SUM_W)) u_chk (
    .a      (a_q),
    .b      (b_q),
    .c      (c_q),
    .psum   (psum_q),
    .accept (accept)
  );

  assign last = (a_q == MAXI) && (b_q == MAXI) && (c_q == MAXI);

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q + 1'b1;
    if (c_q == MAXI) begin
      c_d = '0;
      b_d = b_q + 1'b1;
      if (b_q == MAXI) begin
        b_d = '0;
        a_d = a_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      sc_q        <= '0;
      psum_q      <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      hold_last_q <= 1'b0;
`ifdef SUBSET_ENUM_COUNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            psum_q  <= bus.psum;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
`ifdef SUBSET_ENUM_COUNT_EN
            cnt_q   <= '0;
`endif
          end
        end
        SCAN: begin
          a_q <= a_d;
          b_q <= b_d;
          c_q <= c_d;
          if (accept) begin
            sa_q        <= a_q;
            sb_q        <= b_q;
            sc_q        <= c_q;
            valid_q     <= 1'b1;
            hold_last_q <= last;
            state_q     <= HOLD;
          end else if (last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        HOLD: begin
          if (bus.sol_ready) begin
            valid_q <= 1'b0;
`ifdef SUBSET_ENUM_COUNT_EN
            cnt_q   <= cnt_q + 1'b1;
`endif
            if (hold_last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= SCAN;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.sol_valid = valid_q;
  assign bus.sol_a     = sa_q;
  assign bus.sol_b     = sb_q;
  assign bus.sol_c     = sc_q;
  assign bus.done      = done_q;
`ifdef SUBSET_ENUM_COUNT_EN
  assign bus.sol_count = cnt_q;
`endif
endmodule

// File: tb/tb_subset_sum_enum.sv
// Scoreboard bench for subset_sum_enum: integer reference model feeds an
// expected-triple queue that a negedge monitor drains on each handshake.
module tb_subset_sum_enum;
  import subset_sum_pkg::*;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] c;
  } trip_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  subset_sum_enum_if bus ();

  subset_sum_enum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  trip_t exp_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    rmode = 0;
  int    stall = 0;
  int    hold_cnt = 0;
  int    busy_cnt = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    hs_cyc = 0;
  bit    pv = 0;
  bit    pr = 0;
  trip_t ptrip;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: enumerate all triples directly with integer arithmetic
  task automatic model(input int p);
    trip_t t;
    for (int a = 0; a < DEF_N; a++)
      for (int b = 0; b < DEF_N; b++)
        for (int c = 0; c < DEF_N; c++)
          if ((a + b + c == p) && (a != 0 || (b != 0 && c != 0 && b != c))) begin
            t.a = 5'(a);
            t.b = 5'(b);
            t.c = 5'(c);
            exp_q.push_back(t);
          end
  endtask

  task automatic push3(input int a, input int b, input int c);
    trip_t t;
    t.a = 5'(a);
    t.b = 5'(b);
    t.c = 5'(c);
    exp_q.push_back(t);
  endtask

  // ready policy: 0 always, 1 random, 2 stall 10 cycles per solution, 3 never
  initial begin
    bus.sol_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: bus.sol_ready = 1'b1;
        1: bus.sol_ready = 1'($urandom_range(0, 1));
        2: begin
          if (bus.sol_valid) begin
            bus.sol_ready = (stall >= 10);
            stall++;
          end else begin
            stall = 0;
            bus.sol_ready = 1'b0;
          end
        end
        default: bus.sol_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    trip_t e;
    trip_t cur;
    cur = {bus.sol_a, bus.sol_b, bus.sol_c};
    if (rst_n) begin
      if (bus.busy) busy_cnt++;
      if (bus.sol_valid) begin
        hold_cnt++;
        if (pv && !pr) begin
          n_chk++;
          if (cur != ptrip) begin
            n_fail++;
            $display("FAIL hold_stable: got (%0d,%0d,%0d), held (%0d,%0d,%0d)",
                     cur.a, cur.b, cur.c, ptrip.a, ptrip.b, ptrip.c);
          end
        end
        if (bus.sol_ready) begin
          hs_cyc = cyc;
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_sol: got (%0d,%0d,%0d), expected none",
                     cur.a, cur.b, cur.c);
          end else begin
            e = exp_q.pop_front();
            if (cur != e) begin
              n_fail++;
              $display("FAIL sol_triple: got (%0d,%0d,%0d), expected (%0d,%0d,%0d)",
                       cur.a, cur.b, cur.c, e.a, e.b, e.c);
            end
          end
        end
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    pv = bus.sol_valid;
    pr = bus.sol_ready;
    ptrip = cur;
  end

  task automatic run(input int p, input int mode, input bit use_model, input bit extra);
    int t;
    int d0;
    int nsol;
    int exp_done;
    bit got;
    if (use_model) model(p);
    nsol = exp_q.size();
    rmode = mode;
    @(posedge clk);
    #1;
    hold_cnt = 0;
    busy_cnt = 0;
    d0 = done_cnt;
    bus.psum = 5'(p);
    bus.start = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.psum = 5'($urandom);
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (done_cnt != d0) got = 1;
      else if (extra && i == 20) begin
        bus.start = 1'b1;
        bus.psum = 5'd0;
      end
    end
    bus.start = 1'b0;
    chk($sformatf("done_seen p=%0d", p), int'(got), 1);
    if (mode == 0) exp_done = t + 65 + nsol;
    else if (mode == 2) exp_done = t + 65 + 11 * nsol;
    else exp_done = t + 65 + hold_cnt;
    chk($sformatf("done_cycle p=%0d", p), done_cyc, exp_done);
    chk($sformatf("busy_cycles p=%0d", p), busy_cnt, 64 + hold_cnt);
    chk($sformatf("done_pulse_one p=%0d", p), int'(bus.done), 0);
    chk($sformatf("busy_after p=%0d", p), int'(bus.busy), 0);
    chk($sformatf("sols_left p=%0d", p), exp_q.size(), 0);
    if (mode == 2 && nsol > 0)
      chk("done_after_hs", done_cyc, hs_cyc + 1);
`ifdef SUBSET_ENUM_COUNT_EN
    chk($sformatf("sol_count p=%0d", p), int'(bus.sol_count), nsol);
`endif
    exp_q.delete();
  endtask

  initial begin
    int d0;
    bit seen;
    bus.start = 1'b0;
    bus.psum = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.sol_valid), 0);
    chk("rst_sol", int'({bus.sol_a, bus.sol_b, bus.sol_c}), 0);
    chk("rst_done", int'(bus.done), 0);
    rst_n = 1'b1;

    run(0, 0, 1'b1, 1'b0);
    push3(1, 0, 0);
    run(1, 0, 1'b0, 1'b0);
    push3(0, 1, 2); push3(0, 2, 1); push3(1, 0, 2); push3(1, 1, 1);
    push3(1, 2, 0); push3(2, 0, 1); push3(2, 1, 0); push3(3, 0, 0);
    run(3, 0, 1'b0, 1'b0);
    push3(3, 3, 3);
    run(9, 2, 1'b0, 1'b0);
    run(31, 0, 1'b1, 1'b1);

    // reset while a solution is held
    rmode = 3;
    @(posedge clk);
    #1;
    bus.psum = 5'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = bus.sol_valid;
    end
    chk("hold_reached", int'(seen), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_valid", int'(bus.sol_valid), 0);
    chk("abort_sol", int'({bus.sol_a, bus.sol_b, bus.sol_c}), 0);
    chk("abort_done", int'(bus.done), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rmode = 0;
    hold_cnt = 0;
    d0 = done_cnt;
    rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_no_sol", hold_cnt, 0);
    push3(1, 0, 0);
    run(1, 0, 1'b0, 1'b0);

    run(3, 1, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++)
      run(int'($urandom_range(0, 31)), 1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      run(int'($urandom_range(0, 10)), 0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/subset_sum_enum.md
# subset_sum_enum

Sequential enumerator for the 3-term subset-sum problem. It scans every index triple (a, b, c) over the identity array arr[i] = i and streams out each triple that the partial-sum acceptance rule accepts. It is the generating side of the partial-sum checker: every triple emitted here must be accepted by that checker for the same psum. Host logic starts a scan with a target sum, drains solutions over a valid/ready stream, and receives a done pulse.

## Interface
- N, default 4: array length; indices range over 0..N-1; arr[i] = i.
- IDX_W, default 5: index width (must satisfy 2^IDX_W ≥ N).
- SUM_W, default 5: width of the target-sum input.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle request; honoured only in IDLE.
- psum  in  SUM_W  target sum; sampled on an accepted start.
- busy  out  1  high in SCAN and HOLD.
- sol_valid  out  1  a solution is presented on sol_a/b/c.
- sol_ready  in  1  consumer accepts the solution when sol_valid and sol_ready are both high.
- sol_a, sol_b, sol_c  out  IDX_W each  solution indices.
- done  out  1  one-cycle pulse after the final candidate has been resolved.

## Operation
- Acceptance rule, applied to each candidate: sum = a + b + c is computed at IDX_W+2 bits and compared with psum zero-extended to max(SUM_W, IDX_W+2) bits. A candidate is accepted when sum == psum AND (a ≠ 0 OR (b ≠ 0 AND c ≠ 0 AND b ≠ c)). All indices are always < N by construction.
- Scan order is lexicographic: a is outermost, c is innermost, with c incrementing fastest, from (0,0,0) to (N-1,N-1,N-1). That is N^3 candidates; 64 at the defaults.
- States:
  - IDLE: waits for start. On start, psum_q ← psum, the counters go to (0,0,0), and the state goes to SCAN.
  - SCAN: evaluates one candidate per cycle, then advances the counters.
    - Accepted candidate: the triple is registered into sol_*, sol_valid is set, and the state goes to HOLD.
    - Rejected candidate that is the last one: go to DONE.
    - Any other rejected candidate: stay in SCAN.
  - HOLD: sol_valid = 1 and sol_* stay stable until sol_ready. On the handshake, sol_valid clears and the state goes to DONE if the held triple was the last candidate, otherwise to SCAN.
  - DONE: done = 1 for one cycle, then IDLE.
- start is ignored outside IDLE; psum changes after capture have no effect.
- Reset values: state IDLE, busy 0, sol_valid 0, sol_a/b/c 0, done 0, counters 0, psum_q 0.
- Reset mid-scan or during HOLD aborts immediately. No done pulse and no further solutions are produced.

## Timing
- Start accepted in cycle t → SCAN begins at t+1, evaluating (0,0,0).
- Candidate k (0-based) is evaluated at cycle t+1+k+S, where S is the total number of HOLD cycles so far.
- An accepted candidate evaluated at cycle u → sol_valid is high from u+1.
- The minimum HOLD length is 1 cycle (sol_ready already high).
- With no solutions, done rises at t+1+N^3 (cycle t+65 at the defaults). Each solution adds at least one cycle.
- HOLD → SCAN resumes with the next candidate in the cycle after the handshake. No candidate is skipped or repeated.

## Configuration
- SUBSET_ENUM_COUNT_EN defined: adds the output sol_count (width clog2(N^3+1)). It clears on an accepted start, increments on each sol handshake, and holds its final value from the done pulse until the next start.
- SUBSET_ENUM_COUNT_EN not defined: no port and no counter logic.

## Structure
- subset_sum_pkg contains:
  - N, IDX_W, SUM_W default constants
  - the state enum (IDLE, SCAN, HOLD, DONE)
  - the derived sum width IDX_W+2
- One combinational sub-module, triple_check:
  - inputs a, b, c, psum; output accept
  - implements the acceptance rule
  - shared with the checker bench as its reference model
- The top holds the FSM, the index counters with the last-candidate flag, the output registers and the optional counter.

## Test plan
- psum=0, sol_ready held 1: sol_valid never rises; done pulses exactly at t+65; busy is high for cycles t+1..t+64.
- psum=1: exactly one solution, (1,0,0).
- psum=3, sol_ready=1: 8 solutions in this order: (0,1,2), (0,2,1), (1,0,2), (1,1,1), (1,2,0), (2,0,1), (2,1,0), (3,0,0). sol_count=8 when SUBSET_ENUM_COUNT_EN is defined.
- psum=9, sol_ready held 0 for 10 cycles after sol_valid rises:
  - (3,3,3) is held stable throughout the stall;
  - the handshake is followed by done on the next cycle, because the held triple is the last candidate.
- psum=31: no solutions; done at t+65. A second start pulsed during SCAN is ignored (no restart).
- rst_n asserted during HOLD of the psum=3 run: all outputs go to 0 immediately and no done pulse follows. A new start with psum=1 then yields (1,0,0).
